// File: rtl/fft_frame_serializer_pkg.sv
// Shared fixed-point types for the FFT output path.
// complex_product_t is one complex FFT bin: signed real and imaginary parts,
// each PROD_W bits wide.
package fft_frame_serializer_pkg;

  localparam int unsigned PROD_W = 16;

  typedef struct packed {
    logic signed [PROD_W-1:0] re;
    logic signed [PROD_W-1:0] im;
  } complex_product_t;

  localparam int unsigned CPLX_W = $bits(complex_product_t);

endpackage

// File: rtl/fft_frame_serializer_if.sv
// Bus bundle for fft_frame_serializer.
//   in_valid / in_frame   : parallel FFT frame strobe and data (natural order)
//   m_valid / m_ready     : per-sample stream handshake
//   m_data / m_index      : current sample and its subcarrier index
//   m_last                : marks the sample with index N-1
//   frame_drop            : one-cycle pulse per discarded frame
//   drop_count            : saturating discarded-frame count
// master = the serializer side, slave = FFT source plus stream consumer.
interface fft_frame_serializer_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = $clog2(N),
  parameter int unsigned CNT_W = 8
);
  import fft_frame_serializer_pkg::*;

  logic                      in_valid;
  complex_product_t [N-1:0]  in_frame;
  logic                      m_valid;
  logic                      m_ready;
  complex_product_t          m_data;
  logic [IDX_W-1:0]          m_index;
  logic                      m_last;
  logic                      frame_drop;
  logic [CNT_W-1:0]          drop_count;

  modport master (
    input  in_valid, in_frame, m_ready,
    output m_valid, m_data, m_index, m_last, frame_drop, drop_count
  );

  modport slave (
    output in_valid, in_frame, m_ready,
    input  m_valid, m_data, m_index, m_last, frame_drop, drop_count
  );

endinterface

// File: rtl/fft_frame_serializer_bank.sv
// frame_bank: one N-entry frame store.
//   clk     : clock
//   we      : load all N entries from wr_data in this cycle
//   wr_data : full parallel frame
//   rd_idx  : read address
//   rd_data : entry at rd_idx (combinational read of registered storage)
// Contents are intentionally not reset; readers qualify them with a full flag.
module frame_bank
  import fft_frame_serializer_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     we,
  input  complex_product_t [N-1:0] wr_data,
  input  logic [IDX_W-1:0]         rd_idx,
  output complex_product_t         rd_data
);

  complex_product_t [N-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fft_frame_serializer.sv
// fft_frame_serializer: turns each parallel N-point FFT frame into a stream of
// one complex sample per cycle, using two ping-pong banks so one frame can be
// captured while the other drains. Frames arriving when the write bank is
// still occupied are dropped and counted.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fft_frame_serializer_if.master (frame input, sample stream,
//                drop pulse and saturating drop counter)
module fft_frame_serializer
  import fft_frame_serializer_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = $clog2(N),
  parameter int unsigned CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  fft_frame_serializer_if.master      bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [1:0]        full;
  logic              wr_bank;
  logic              rd_bank;
  logic [IDX_W-1:0]  rd_idx;
  logic              frame_drop_q;
  logic [CNT_W-1:0]  drop_count_q;

  complex_product_t  rd_data0;
  complex_product_t  rd_data1;

  logic              m_valid_w;
  logic              at_last;
  logic              handshake;
  logic              capture;
  logic              drop;

  // Capture/drop is decided on registered flags only: a bank freed by the
  // last handshake in this cycle is not reusable until the next cycle.
  assign m_valid_w = full[rd_bank];
  assign at_last   = (rd_idx == LAST_IDX);
  assign handshake = m_valid_w && bus.m_ready;
  assign capture   = bus.in_valid && !full[wr_bank];
  assign drop      = bus.in_valid &&  full[wr_bank];

  frame_bank #(.N(N), .IDX_W(IDX_W)) u_bank0 (
    .clk     (clk),
    .we      (capture && !wr_bank),
    .wr_data (bus.in_frame),
    .rd_idx  (rd_idx),
    .rd_data (rd_data0)
  );

  frame_bank #(.N(N), .IDX_W(IDX_W)) u_bank1 (
    .clk     (clk),
    .we      (capture && wr_bank),
    .wr_data (bus.in_frame),
    .rd_idx  (rd_idx),
    .rd_data (rd_data1)
  );

  // A capture needs full[wr_bank]=0 and a last handshake needs
  // full[rd_bank]=1, so in one cycle they always touch different flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      full         <= '0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      rd_idx       <= '0;
      frame_drop_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      frame_drop_q <= drop;
      if (drop && (drop_count_q != '1)) begin
        drop_count_q <= drop_count_q + CNT_W'(1);
      end

      if (capture) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end

      if (handshake) begin
        if (at_last) begin
          rd_idx        <= '0;
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end else begin
          rd_idx <= rd_idx + IDX_W'(1);
        end
      end
    end
  end

  assign bus.m_valid    = m_valid_w;
  assign bus.m_data     = rd_bank ? rd_data1 : rd_data0;
  assign bus.m_index    = rd_idx;
  assign bus.m_last     = m_valid_w && at_last;
  assign bus.frame_drop = frame_drop_q;
  assign bus.drop_count = drop_count_q;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Self-checking bench for fft_frame_serializer (N=8, CNT_W=8).
// A frame-queue model (at most two stored frames, read position into the
// oldest) predicts every output; a negedge process compares against it each
// cycle, and directed scenarios add literal expectations.
module tb_fft_frame_serializer;
  import fft_frame_serializer_pkg::*;

  localparam int unsigned N       = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  typedef complex_product_t [N-1:0] frame_t;

  logic clk;
  logic reset;

  fft_frame_serializer_if #(.N(N), .CNT_W(CNT_W)) bus ();

  fft_frame_serializer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  frame_t mq[$];
  int     mpos;
  bit     mdrop;
  int     mcnt;
  bit     model_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      mpos  = 0;
      mdrop = 1'b0;
      mcnt  = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      bit was_full;
      was_full = (mq.size() == 2);
      mdrop = 1'b0;
      if (mq.size() > 0 && bus.m_ready) begin
        mpos++;
        if (mpos == N) begin
          mpos = 0;
          void'(mq.pop_front());
        end
      end
      if (bus.in_valid) begin
        if (was_full) begin
          mdrop = 1'b1;
          if (mcnt < CNT_MAX) mcnt++;
        end else begin
          mq.push_back(bus.in_frame);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      bit ev;
      ev = (mq.size() > 0);
      chk("m_valid", 64'(bus.m_valid), 64'(ev));
      chk("m_index", 64'(bus.m_index), 64'(mpos));
      chk("m_last", 64'(bus.m_last), 64'(ev && mpos == N - 1));
      if (ev) chk("m_data", 64'(bus.m_data), 64'(mq[0][mpos]));
      chk("frame_drop", 64'(bus.frame_drop), 64'(mdrop));
      chk("drop_count", 64'(bus.drop_count), 64'(mcnt));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic frame_t mk(input int base);
    frame_t f;
    for (int k = 0; k < N; k++) begin
      f[k].re = PROD_W'(base + k);
      f[k].im = PROD_W'(-(base + k));
    end
    return f;
  endfunction

  function automatic frame_t rnd_frame();
    frame_t f;
    for (int k = 0; k < N; k++) f[k] = complex_product_t'($urandom);
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input frame_t f);
    bus.in_valid = 1'b1;
    bus.in_frame = f;
    tick();
    bus.in_valid = 1'b0;
  endtask

  int hs;

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_frame = '0;
    bus.m_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset m_valid", 64'(bus.m_valid), 64'd0);
    chk("reset m_last", 64'(bus.m_last), 64'd0);
    chk("reset drop_count", 64'(bus.drop_count), 64'd0);
    chk("reset frame_drop", 64'(bus.frame_drop), 64'd0);

    // Single frame: samples k / -k, one per cycle starting the next cycle.
    bus.m_ready = 1'b1;
    strobe(mk(0));
    for (int k = 0; k < N; k++) begin
      chk("single valid", 64'(bus.m_valid), 64'd1);
      chk("single index", 64'(bus.m_index), 64'(k));
      chk("single re", 64'(int'(bus.m_data.re)), 64'(k));
      chk("single im", 64'(int'(bus.m_data.im)), 64'(-k));
      chk("single last", 64'(bus.m_last), 64'(k == N - 1));
      tick();
    end
    chk("single idle", 64'(bus.m_valid), 64'd0);

    // Back-pressure: ready alternates 1,0,... -> 8 handshakes in 15 cycles.
    bus.m_ready = 1'b0;
    strobe(mk(16));
    hs = 0;
    for (int c = 0; c < 15; c++) begin
      bus.m_ready = (c % 2 == 0);
      #1;
      if (bus.m_valid && bus.m_ready) begin
        chk("bp order", 64'(int'(bus.m_data.re)), 64'(16 + hs));
        hs++;
      end
      tick();
    end
    chk("bp handshakes", 64'(hs), 64'd8);
    chk("bp idle", 64'(bus.m_valid), 64'd0);

    // Ping-pong: A at cycle 0, B at cycle 4, 16 samples with no gap.
    bus.m_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      bus.in_valid = (c == 0 || c == 4);
      bus.in_frame = (c == 0) ? mk(32) : mk(64);
      if (c >= 1) begin
        chk("pp valid", 64'(bus.m_valid), 64'(c <= 16));
        if (c <= 16)
          chk("pp re", 64'(int'(bus.m_data.re)), 64'(((c <= 8) ? 32 : 64) + (c - 1) % 8));
        chk("pp no drop", 64'(bus.frame_drop), 64'd0);
      end
      tick();
    end
    bus.in_valid = 1'b0;

    // Overflow: three frames with ready low; third dropped.
    bus.m_ready = 1'b0;
    strobe(mk(100));
    strobe(mk(120));
    strobe(mk(140));
    chk("ovf drop pulse", 64'(bus.frame_drop), 64'd1);
    chk("ovf count", 64'(bus.drop_count), 64'd1);
    tick();
    chk("ovf pulse once", 64'(bus.frame_drop), 64'd0);
    bus.m_ready = 1'b1;
    for (int k = 0; k < 2 * N; k++) begin
      chk("ovf re", 64'(int'(bus.m_data.re)), 64'(((k < N) ? 100 : 120) + k % N));
      tick();
    end
    chk("ovf idle", 64'(bus.m_valid), 64'd0);

    // Collision: both banks full, new frame on the index-7 handshake.
    bus.m_ready = 1'b0;
    strobe(mk(200));
    strobe(mk(220));
    bus.m_ready = 1'b1;
    for (int k = 0; k < N - 1; k++) tick();
    chk("col at last", 64'(bus.m_last), 64'd1);
    strobe(mk(240));
    chk("col drop pulse", 64'(bus.frame_drop), 64'd1);
    chk("col count", 64'(bus.drop_count), 64'd2);
    chk("col next frame", 64'(int'(bus.m_data.re)), 64'd220);
    for (int k = 0; k < N; k++) tick();
    chk("col freed empty", 64'(bus.m_valid), 64'd0);

    // Reset mid-drain at index 3.
    strobe(mk(10));
    for (int k = 0; k < 3; k++) tick();
    chk("mid index", 64'(bus.m_index), 64'd3);
    reset = 1'b1;
    tick();
    chk("rst m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst drop_count", 64'(bus.drop_count), 64'd0);
    reset = 1'b0;

    // Saturation: 300 frames with ready low -> 298 drops, capped at 255.
    bus.m_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.in_frame = mk(i);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("sat count", 64'(bus.drop_count), 64'd255);
    tick();
    chk("sat hold", 64'(bus.drop_count), 64'd255);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      bus.in_valid = ($urandom_range(0, 5) == 0);
      bus.in_frame = rnd_frame();
      bus.m_ready  = ($urandom_range(0, 9) < 7);
      reset        = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.m_ready  = 1'b1;
    for (int c = 0; c < 3 * N; c++) tick();
    chk("final idle", 64'(bus.m_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_serializer.md
# fft_frame_serializer

Downstream of `fft_N_rad2`, this block converts each parallel N-point FFT result into a stream of one complex sample per cycle with a valid/ready handshake. The stream feeds the per-subcarrier consumers: equalizer and demapper. It double-buffers frames (ping-pong) so one frame can be captured while the previous one drains. It also reports frames it had to drop because the consumer was too slow.

## Interface
Parameters:
- `N`, 8: FFT size (power of two, ≥4); samples per frame.
- `IDX_W`, `$clog2(N)`: subcarrier index width.
- `CNT_W`, 8: width of the dropped-frame counter.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, synchronous, active-high.
- `in_valid`, input, 1: single-cycle frame strobe (FFT `out_valid`).
- `in_frame`, input, `complex_product_t [N-1:0]`: FFT output, natural order, index 0 = DC.
- `m_valid`, output, 1: stream sample valid.
- `m_ready`, input, 1: consumer accepts the sample.
- `m_data`, output, `complex_product_t`: current sample.
- `m_index`, output, `IDX_W`: subcarrier index of `m_data`.
- `m_last`, output, 1: high with the sample of index N-1.
- `frame_drop`, output, 1: one-cycle pulse when an incoming frame is discarded.
- `drop_count`, output, `CNT_W`: saturating count of discarded frames.

## Operation
- Storage is two banks, each holding N `complex_product_t`. Each bank has a `full` flag.
- `wr_bank` and `rd_bank` are 1-bit pointers.
- Read index is `rd_idx` (`IDX_W` bits).
- **Capture:** when `in_valid` is high and `full[wr_bank]` is 0 (registered value):
  - write all N samples into `wr_bank`;
  - set `full[wr_bank]`;
  - toggle `wr_bank`.
- **Drop:** when `in_valid` is high and `full[wr_bank]` is 1:
  - the frame is discarded;
  - `frame_drop` pulses the next cycle;
  - `drop_count` increments and saturates at 2^CNT_W−1;
  - banks and pointers are unchanged.
- **Drain:**
  - `m_valid` = `full[rd_bank]`.
  - `m_data` = `bank[rd_bank][rd_idx]`.
  - `m_index` = `rd_idx`.
  - `m_last` = `m_valid` && (`rd_idx` == N−1).
- **Handshake:** occurs when `m_valid` && `m_ready`. On each handshake `rd_idx` increments. When the handshake coincides with `m_last`:
  - `rd_idx` goes to 0;
  - `full[rd_bank]` is cleared;
  - `rd_bank` toggles.
- While `m_valid` is high and `m_ready` is low, `m_data`, `m_index` and `m_last` hold stable.
- **Same cycle, different banks:** a capture and a last-handshake that address different banks both take effect.
- **Same cycle, same bank:** a capture arriving while both banks are full and the last sample is being accepted is dropped. There is no same-cycle bypass; the decision uses registered `full` flags only.
- **Reset:**
  - `full` = 0, pointers = 0, `rd_idx` = 0, `frame_drop` = 0, `drop_count` = 0, so `m_valid` = `m_last` = 0.
  - Bank contents are not reset; `m_data` is don't-care while `m_valid` = 0.
  - Reset mid-drain abandons both frames immediately.

## Timing
- **Latency:** `in_valid` at cycle t into an empty design gives `m_valid` = 1 with index 0 at t+1.
- **Throughput:** one sample per cycle with `m_ready` held high. A frame drains in N cycles.
- **Sustained rate:** frames arriving every ≥N cycles with `m_ready` = 1 never drop.
- **Output paths:**
  - `m_valid`, `m_index` and `m_last` are pure functions of registered state.
  - `m_data` is a registered-storage mux.
  - There is no combinational path from `m_ready` or `in_valid` to any output.
- `frame_drop` is registered and asserts one cycle after the dropped `in_valid`.
- `in_frame` is sampled only in the cycle `in_valid` = 1.

## Structure
- `complex_product_t` and its width constants come from the existing shared fixed-point package. Nothing new is added to it.
- One sub-module, `frame_bank`: N-entry register array with a parallel write enable and an indexed read port, instantiated twice.
- Pointer, flag, index and counter control lives in the top level.

## Test plan
- **Single frame:** N=8, reset, one `in_valid` with samples 0..7 (real = k, imag = −k), `m_ready` = 1.
  - `m_valid` high from t+1 for 8 cycles.
  - `m_index` 0..7; `m_last` only on index 7.
  - Outputs idle afterward.
- **Back-pressure:** same frame with `m_ready` toggling 1,0,1,0…
  - 8 handshakes over 15 cycles.
  - Data stable during stalls; no loss or duplication.
- **Ping-pong:** frames A and B strobed 4 cycles apart with `m_ready` = 1.
  - A0..A7 then B0..B7 back-to-back, with no gap cycle.
  - `frame_drop` never asserts.
- **Overflow:** `m_ready` = 0, three frames strobed.
  - Third frame dropped; `frame_drop` pulses once; `drop_count` = 1.
  - Releasing `m_ready` yields frames 1 then 2 intact.
- **Collision:** both banks full, and a new `in_valid` coincides with the index-7 handshake.
  - New frame dropped; `drop_count` increments.
  - Freed bank is empty the next cycle.
- **Reset mid-drain and saturation:**
  - Reset at index 3: `m_valid` = 0 next cycle and `drop_count` = 0.
  - Then 300 overflowing frames with `CNT_W` = 8: `drop_count` saturates at 255.
